varint_emit: RTL and testbench

VARINT_EMIT -- requirements
Module: varint_emit

---
 rtl/varint_emit_pkg.sv | 8 +
 rtl/varint_emit_len.sv | 17 +
 rtl/varint_emit.sv | 62 ++++++
 tb/tb_varint_emit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/varint_emit_pkg.sv
// varint_emit_pkg: byte width, default varint length and FSM state type shared by the varint blocks
`ifndef BYTE
`define BYTE 8
`endif
package varint_emit_pkg;
   localparam int VARINT_MAX_BYTES = 10;
   typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/varint_emit_len.sv
// varint_len: varint length = index of the first byte with a clear continuation bit, plus one
// A varint with every continuation bit set saturates at MAX_BYTES.
module varint_len
   import varint_emit_pkg::*;
#(
   parameter int MAX_BYTES = VARINT_MAX_BYTES,
   localparam int LW = $clog2(MAX_BYTES + 1)
) (
   input  logic [`BYTE*MAX_BYTES-1:0] i_data,
   output logic [LW-1:0]              o_len
);
   always_comb begin
      o_len = LW'(MAX_BYTES);
      for (int k = MAX_BYTES - 1; k >= 0; k--)
         o_len = i_data[`BYTE*k + 7] ? o_len : LW'(k + 1);
   end
endmodule

// File: rtl/varint_emit.sv
// varint_emit: captures an encoded varint and streams it out one byte per valid/ready handshake
// Optional macro VARINT_EMIT_CNT_EN adds a 32-bit count of output handshakes (byte_count).
module varint_emit
   import varint_emit_pkg::*;
#(
   parameter int MAX_BYTES = VARINT_MAX_BYTES,
   localparam int LW = $clog2(MAX_BYTES + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [`BYTE*MAX_BYTES-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [`BYTE-1:0]           out_byte,
   output logic                       out_last
`ifdef VARINT_EMIT_CNT_EN
   ,
   output logic [31:0]                byte_count
`endif
);
   state_t r_state, w_next;
   logic [MAX_BYTES-1:0][`BYTE-1:0] r_hold;
   logic [LW-1:0] r_idx, r_len, w_len;
   logic w_in_hs, w_out_hs;

   varint_len #(.MAX_BYTES(MAX_BYTES)) u_len (.i_data(in_data), .o_len(w_len));

   assign in_ready  = r_state == IDLE;
   assign out_valid = r_state == EMIT;
   assign out_last  = out_valid && r_idx == r_len - LW'(1);
   assign out_byte  = r_hold[r_idx];
   assign w_in_hs   = in_valid && in_ready;
   assign w_out_hs  = out_valid && out_ready;

   always_comb
      w_next = (r_state == IDLE) ? (in_valid ? EMIT : IDLE) : ((out_ready && out_last) ? IDLE : EMIT);

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;

   // idx returns to 0 on the last byte so it never points past the varint
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_hold <= '0;
         r_idx  <= '0;
         r_len  <= '0;
      end else if (w_in_hs) begin
         r_hold <= in_data;
         r_len  <= w_len;
         r_idx  <= '0;
      end else if (w_out_hs)
         r_idx <= out_last ? '0 : r_idx + LW'(1);

`ifdef VARINT_EMIT_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) byte_count <= '0;
      else if (w_out_hs) byte_count <= byte_count + 32'd1;
`endif
endmodule

// File: tb/tb_varint_emit.sv
// tb_varint_emit: scoreboard bench for varint_emit; expected bytes are queued when a varint is sent
// Also checks byte_count when built with VARINT_EMIT_CNT_EN.
module tb_varint_emit;
   localparam int MB = 10;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, out_last;
   logic [8*MB-1:0] in_data = '0;
   logic [7:0] out_byte;
`ifdef VARINT_EMIT_CNT_EN
   logic [31:0] byte_count;
`endif
   int n_checks = 0, n_fail = 0;
   logic [8:0] sb[$];

   always #5 clk = ~clk;

   varint_emit #(.MAX_BYTES(MB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last)
`ifdef VARINT_EMIT_CNT_EN
      , .byte_count(byte_count)
`endif
   );

   task automatic push_exp(input logic [8*MB-1:0] d);
      int len = MB;
      for (int k = MB - 1; k >= 0; k--) if (!d[8*k+7]) len = k + 1;
      for (int k = 0; k < len; k++) sb.push_back({d[8*k +: 8], k == len - 1});
   endtask

   task automatic send(input logic [8*MB-1:0] d, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      in_valid = 1'b1;
      in_data = d;
      push_exp(d);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_last, out_byte, in_ready} !== {2'b00, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_release: got valid=%b last=%b byte=%h ready=%b, required 0 0 00 1", out_valid, out_last, out_byte, in_ready);
      end
`ifdef VARINT_EMIT_CNT_EN
      n_checks++;
      if (byte_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d, required 0", byte_count);
      end
`endif
   endtask

   task automatic test_150();
      bit ok;
      logic [8:0] e;
      out_ready = 1'b1;
      send(80'h0196, ok);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e = 9'h1FF;
         if (sb.size() != 0) e = sb.pop_front();
         n_checks++;
         if (!ok || out_valid !== 1'b1 || {out_byte, out_last} !== e) begin
            n_fail++;
            $display("FAIL v150_byte%0d: got valid=%b byte=%h last=%b, required valid=1 byte=%h last=%b", i, out_valid, out_byte, out_last, e[8:1], e[0]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL v150_idle: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
      end
   endtask

   task automatic test_zero();
      bit ok;
      logic [8:0] e;
      out_ready = 1'b1;
      send(80'h00, ok);
      @(negedge clk);
      e = 9'h1FF;
      if (sb.size() != 0) e = sb.pop_front();
      n_checks++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || {out_byte, out_last} !== e) begin
         n_fail++;
         $display("FAIL zero_byte: got valid=%b ready=%b byte=%h last=%b, required valid=1 ready=0 byte=%h last=%b", out_valid, in_ready, out_byte, out_last, e[8:1], e[0]);
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_ready_n2: got ready=%b valid=%b, required ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_max();
      bit ok;
      int hs = 0;
      logic [8:0] e;
      out_ready = 1'b1;
      send(80'h01FFFFFFFFFFFFFFFFFF, ok);
      for (int t = 0; t < 30 && sb.size() != 0; t++) begin
         @(negedge clk);
         if (out_valid) begin
            e = sb.pop_front();
            hs++;
            n_checks++;
            if ({out_byte, out_last} !== e || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL max_byte%0d: got byte=%h last=%b ready=%b, required byte=%h last=%b ready=0", hs - 1, out_byte, out_last, in_ready, e[8:1], e[0]);
            end
         end
      end
      n_checks++;
      if (!ok || hs != 10) begin
         n_fail++;
         $display("FAIL max_handshakes: got %0d, required 10", hs);
      end
      sb.delete();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL max_idle: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit pat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [8:0] e;
      out_ready = 1'b0;
      send(80'h0196, ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = pat[i];
         e = 9'h1FF;
         if (sb.size() != 0) e = sb[0];
         n_checks++;
         if (!ok || out_valid !== 1'b1 || {out_byte, out_last} !== e) begin
            n_fail++;
            $display("FAIL bp_cycle%0d: got valid=%b byte=%h last=%b, required valid=1 byte=%h last=%b", i, out_valid, out_byte, out_last, e[8:1], e[0]);
         end
         if (pat[i] && sb.size() != 0) void'(sb.pop_front());
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL bp_done: got valid=%b pending=%0d, required valid=0 pending=0", out_valid, sb.size());
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [8:0] e;
      out_ready = 1'b1;
      send(80'h01FFFFFFFFFFFFFFFFFF, ok);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (!ok || out_valid !== 1'b1 || {out_byte, out_last} !== e) begin
         n_fail++;
         $display("FAIL rmid_first: got valid=%b byte=%h last=%b, required valid=1 byte=%h last=%b", out_valid, out_byte, out_last, e[8:1], e[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_abort: got valid=%b last=%b, required valid=0 last=0", out_valid, out_last);
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_byte !== 8'h00) begin
         n_fail++;
         $display("FAIL rmid_release: got ready=%b valid=%b byte=%h, required 1 0 00", in_ready, out_valid, out_byte);
      end
      send(80'h05, ok);
      @(negedge clk);
      e = 9'h1FF;
      if (sb.size() != 0) e = sb.pop_front();
      n_checks++;
      if (!ok || out_valid !== 1'b1 || {out_byte, out_last} !== e) begin
         n_fail++;
         $display("FAIL rmid_next: got valid=%b byte=%h last=%b, required valid=1 byte=%h last=%b", out_valid, out_byte, out_last, e[8:1], e[0]);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_single: got valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      bit ok, all_ok = 1'b1;
      int hs = 0;
      logic [8:0] e;
      logic [8*MB-1:0] vec[2] = '{80'h0196, 80'h01FFFFFFFFFFFFFFFFFF};
`ifdef VARINT_EMIT_CNT_EN
      logic [31:0] c0 = byte_count;
`endif
      out_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         send(vec[v], ok);
         all_ok &= ok;
         for (int t = 0; t < 30 && sb.size() != 0; t++) begin
            @(negedge clk);
            if (out_valid) begin
               e = sb.pop_front();
               hs++;
               n_checks++;
               if ({out_byte, out_last} !== e) begin
                  n_fail++;
                  $display("FAIL b2b_byte%0d: got byte=%h last=%b, required byte=%h last=%b", hs - 1, out_byte, out_last, e[8:1], e[0]);
               end
            end
         end
         sb.delete();
      end
      @(negedge clk);
      n_checks++;
      if (!all_ok || hs != 12) begin
         n_fail++;
         $display("FAIL b2b_handshakes: got %0d, required 12", hs);
      end
`ifdef VARINT_EMIT_CNT_EN
      n_checks++;
      if (byte_count - c0 !== 32'd12) begin
         n_fail++;
         $display("FAIL b2b_byte_count: got %0d, required 12", byte_count - c0);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_150();
      test_zero();
      test_max();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
